// File: rtl/sha3_theta_elt_gen.sv
// Keccak-f theta, first half: column parities C and correction lanes D,
// two-stage pipeline with a delay-matched copy of the state alongside.

module sha3_theta_lane #(
  parameter int VEC_W = 64
) (
  input  logic [4:0][VEC_W-1:0] col,
  input  logic [VEC_W-1:0]      c_left,
  input  logic [VEC_W-1:0]      c_right,
  output logic [VEC_W-1:0]      c,
  output logic [VEC_W-1:0]      d
);
  // c is this column's parity from the live input; d uses the stage-1
  // parities of the neighbouring columns, so the two are a stage apart.
  always_comb begin
    c = col[0] ^ col[1] ^ col[2] ^ col[3] ^ col[4];
    d = c_left ^ {c_right[VEC_W-2:0], c_right[VEC_W-1]};
  end
endmodule

module sha3_theta_elt_gen #(
  parameter string LOGIC_STYLE = "basic"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample,
  input  logic             hold,
  input  logic [4:0][63:0] isa,
  input  logic [4:0][63:0] isb,
  input  logic [4:0][63:0] isc,
  input  logic [4:0][63:0] isd,
  input  logic [4:0][63:0] ise,
  output logic [4:0][63:0] osa,
  output logic [4:0][63:0] osb,
  output logic [4:0][63:0] osc,
  output logic [4:0][63:0] osd,
  output logic [4:0][63:0] ose,
  output logic [4:0][63:0] elt,
  output logic             good
);
  localparam int NUM_LANES = 5;
  localparam int VEC_W     = 64;
  localparam int STAGES    = 2;

  if (LOGIC_STYLE != "basic") begin : g_bad_style
    $error("sha3_theta_elt_gen: unsupported LOGIC_STYLE");
  end

  typedef struct packed {
    logic [NUM_LANES-1:0][VEC_W-1:0] a;
    logic [NUM_LANES-1:0][VEC_W-1:0] b;
    logic [NUM_LANES-1:0][VEC_W-1:0] c;
    logic [NUM_LANES-1:0][VEC_W-1:0] d;
    logic [NUM_LANES-1:0][VEC_W-1:0] e;
  } planes_t;

  planes_t                          in_p, s1_p, s2_p;
  logic [NUM_LANES-1:0][VEC_W-1:0]  c_nxt, c1, d_nxt, d2;
  logic [STAGES:1]                  vld_pipe;

  assign in_p = {isa, isb, isc, isd, ise};

  for (genvar x = 0; x < NUM_LANES; x++) begin : g_col
    sha3_theta_lane #(.VEC_W(VEC_W)) u_lane (
      .col     ({ise[x], isd[x], isc[x], isb[x], isa[x]}),
      .c_left  (c1[(x + NUM_LANES - 1) % NUM_LANES]),
      .c_right (c1[(x + 1) % NUM_LANES]),
      .c       (c_nxt[x]),
      .d       (d_nxt[x])
    );
  end

  // Bubbles load too: data is only meaningful where the matching valid is set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe <= '0;
      s1_p     <= '0;
      c1       <= '0;
      s2_p     <= '0;
      d2       <= '0;
    end else if (!hold) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], sample};
      s1_p     <= in_p;
      c1       <= c_nxt;
      s2_p     <= s1_p;
      d2       <= d_nxt;
    end
  end

  assign osa  = s2_p.a;
  assign osb  = s2_p.b;
  assign osc  = s2_p.c;
  assign osd  = s2_p.d;
  assign ose  = s2_p.e;
  assign elt  = d2;
  assign good = vld_pipe[STAGES];
endmodule

// File: tb/tb_sha3_theta_elt_gen.sv
// Randomized bench for sha3_theta_elt_gen against a state-level theta model.

module tb_sha3_theta_elt_gen;
  logic             clk = 1'b0;
  logic             rst, sample, hold, good;
  logic [4:0][63:0] isa, isb, isc, isd, ise;
  logic [4:0][63:0] osa, osb, osc, osd, ose, elt;

  always #5 clk = ~clk;

  sha3_theta_elt_gen #(.LOGIC_STYLE("basic")) dut (
    .clk(clk), .rst(rst), .sample(sample), .hold(hold),
    .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .osa(osa), .osb(osb), .osc(osc), .osd(osd), .ose(ose),
    .elt(elt), .good(good)
  );

  // cur_st[y][x]: plane y, column x
  bit [4:0][4:0][63:0] cur_st;
  bit cur_s, cur_h, cur_r;

  assign isa = cur_st[0];
  assign isb = cur_st[1];
  assign isc = cur_st[2];
  assign isd = cur_st[3];
  assign ise = cur_st[4];
  assign sample = cur_s;
  assign hold   = cur_h;
  assign rst    = cur_r;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit [4:0][63:0] theta_d(input bit [4:0][4:0][63:0] st);
    bit [4:0][63:0] c, d;
    for (int x = 0; x < 5; x++) begin
      c[x] = '0;
      for (int y = 0; y < 5; y++) c[x] ^= st[y][x];
    end
    for (int x = 0; x < 5; x++)
      d[x] = c[(x + 4) % 5] ^ ((c[(x + 1) % 5] << 1) | (c[(x + 1) % 5] >> 63));
    return d;
  endfunction

  function automatic bit [4:0][4:0][63:0] rand_state();
    bit [4:0][4:0][63:0] st;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++) st[y][x] = {$urandom, $urandom};
    return st;
  endfunction

  // Reference: a two-deep delay line of whole states; known marks data worth checking.
  typedef struct packed {
    bit v;
    bit known;
    bit [4:0][4:0][63:0] st;
  } ent_t;
  ent_t m1, m2;

  task automatic model_edge();
    if (!cur_r) begin
      m1 = '0; m1.known = 1'b1;
      m2 = '0; m2.known = 1'b1;
    end else if (!cur_h) begin
      m2 = m1;
      m1.v = cur_s;
      m1.known = cur_s;
      m1.st = cur_st;
    end
  endtask

  task automatic check_outputs();
    bit [4:0][63:0] d;
    logic [4:0][4:0][63:0] os;
    os = {ose, osd, osc, osb, osa};
    chk_eq("good", {63'd0, good}, {63'd0, m2.v});
    if (m2.known) begin
      d = theta_d(m2.st);
      for (int x = 0; x < 5; x++) begin
        chk_eq($sformatf("elt[%0d]", x), elt[x], d[x]);
        for (int y = 0; y < 5; y++)
          chk_eq($sformatf("os[y%0d][x%0d]", y, x), os[y][x], m2.st[y][x]);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_in(input bit s, input bit h, input bit r, input bit [4:0][4:0][63:0] st);
    cur_s = s; cur_h = h; cur_r = r; cur_st = st;
  endtask

  bit [4:0][4:0][63:0] zst, st;
  int n;

  initial begin
    zst = '0;
    m1 = '0; m2 = '0;
    set_in(1'b1, 1'b0, 1'b0, rand_state());

    // reset with live sample and random inputs
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, i[0], 1'b0, rand_state());
      cyc();
    end
    set_in(1'b0, 1'b0, 1'b1, rand_state());
    cyc();

    // single bit
    st = '0; st[0][0] = 64'h1;
    set_in(1'b1, 1'b0, 1'b1, st);
    cyc();
    set_in(1'b0, 1'b0, 1'b1, zst);
    cyc();
    chk_eq("single_good", {63'd0, good}, 64'd1);
    chk_eq("single_d0", elt[0], 64'h0);
    chk_eq("single_d1", elt[1], 64'h1);
    chk_eq("single_d4", elt[4], 64'h2);
    chk_eq("single_osa0", osa[0], 64'h1);
    cyc();
    chk_eq("single_one_cycle", {63'd0, good}, 64'd0);

    // rotate wrap
    st = '0; st[1][2] = 64'h8000000000000000;
    set_in(1'b1, 1'b0, 1'b1, st);
    cyc();
    set_in(1'b0, 1'b0, 1'b1, zst);
    cyc();
    chk_eq("wrap_d1", elt[1], 64'h1);
    chk_eq("wrap_d3", elt[3], 64'h8000000000000000);
    chk_eq("wrap_d0", elt[0], 64'h0);
    cyc();

    // back-to-back
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b0, 1'b1, rand_state());
      cyc();
    end
    set_in(1'b0, 1'b0, 1'b1, zst);
    for (int i = 0; i < 3; i++) cyc();

    // hold after sample; a sample during hold must not be captured
    set_in(1'b1, 1'b0, 1'b1, rand_state());
    cyc();
    n = 1;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b1, 1'b1, rand_state());
      cyc();
      n++;
    end
    set_in(1'b0, 1'b0, 1'b1, zst);
    for (int i = 0; i < 10 && !good; i++) begin
      cyc();
      n++;
    end
    chk_eq("hold_latency", 64'(n), 64'd5);
    // hold while good is high: outputs must stay put
    set_in(1'b0, 1'b1, 1'b1, rand_state());
    cyc();
    chk_eq("hold_good_stable", {63'd0, good}, 64'd1);
    cyc();
    set_in(1'b0, 1'b0, 1'b1, zst);
    for (int i = 0; i < 3; i++) cyc();

    // reset mid-flight discards the in-flight state
    set_in(1'b1, 1'b0, 1'b1, rand_state());
    cyc();
    set_in(1'b0, 1'b0, 1'b0, rand_state());
    cyc();
    set_in(1'b0, 1'b0, 1'b1, zst);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (good) n++;
    end
    chk_eq("rst_flush_no_good", 64'(n), 64'd0);
    set_in(1'b1, 1'b0, 1'b1, rand_state());
    cyc();
    set_in(1'b0, 1'b0, 1'b1, zst);
    cyc();
    chk_eq("rst_new_good", {63'd0, good}, 64'd1);
    cyc();

    // random soak
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 30) != 0), rand_state());
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sha3_theta_elt_gen.md
# sha3_theta_elt_gen

First half of the Keccak-f theta step, directly upstream of the theta updater. It takes the 25-lane state as five 5-lane planes and computes the five column parities C[x]. It then derives the five theta correction lanes D[x] and presents them as `elt` alongside a delay-matched copy of the state. Its `good` output drives the updater's `sample` input, so the updater registers `isX ^ elt` on the cycle the data is valid.

## Interface
Parameters:
- LOGIC_STYLE, "basic": implementation style. Only "basic" (plain inferred logic and registers) is legal; any other value raises an elaboration `$error`.

Ports:
- clk  in  1  clock; all registers on rising edge.
- rst  in  1  synchronous, active-low reset.
- sample  in  1  input state valid this cycle.
- hold  in  1  pipeline freeze (downstream stall).
- isa, isb, isc, isd, ise  in  64 x5 each  state planes y=0..4; index [x] is the column.
- osa, osb, osc, osd, ose  out  64 x5 each  state planes, delayed to align with `elt`.
- elt  out  64 x5  theta correction lanes D[0..4].
- good  out  1  `osX`/`elt` valid; connects to the updater's `sample`.

## Operation
- Column parity: C[x] = isa[x]^isb[x]^isc[x]^isd[x]^ise[x], for x=0..4.
- Correction: D[x] = C[(x+4)%5] ^ rotl64(C[(x+1)%5], 1).
  - rotl64 by 1 moves bit i to bit (i+1) mod 64; bit 63 wraps to bit 0.
  - Column indices wrap mod 5.
- Two register stages, each with a valid bit (v1, v2):
  - Stage 1 captures the 25 input lanes and the 5 C lanes, and v1 <= sample.
  - Stage 2 captures the stage-1 lanes and D computed from stage-1 C, and v2 <= v1.
- Outputs come straight from stage-2 registers; no combinational path from inputs to outputs.
- hold=1:
  - Neither stage updates; all data and valid bits keep their value.
  - `sample` is ignored; the upstream must keep the state until hold drops.
  - `good` keeps its value. The downstream owns the stall, so the updater must also gate on hold.
- hold=0: both stages advance every cycle.
  - Stage registers load unconditionally, so a bubble (sample=0) propagates as valid=0 with don't-care data.
  - The bench checks data only when good=1.
- No ordering state and no counters beyond the valid bits. Independent states can enter back-to-back with one per cycle.

## Timing
- Reset (rst=0 at a rising edge) clears v1, v2 and all data registers to 0:
  - good=0
  - every osX[x] = 0
  - every elt[x] = 0
- Reset wins over hold and sample in the same cycle.
- Reset mid-operation discards every in-flight state. The first valid output after release is the first sample taken after release.
- Latency: sample=1 at edge N (hold=0) gives good=1 with matching data after edge N+2, i.e. 2 cycles.
  - Each hold cycle between N and N+2 adds one cycle.
- Throughput: 1 state/cycle with hold=0.
- Simultaneous sample=1 and hold=1: sample is not captured, and the pipeline is unchanged.
- hold during good=1: good and data stay stable for every held cycle, then advance on the first edge with hold=0.

## Test plan
- Reset: drive rst=0 for 2 cycles with random inputs and sample=1 -> good=0 and all osX/elt = 0 during and on the first cycle after release.
- Single bit: isa[0]=0x1, all other lanes 0, sample=1 one cycle -> 2 cycles later good=1 for exactly 1 cycle with:
  - elt = {0, 0x1, 0, 0, 0x2}
  - osa[0]=0x1, all other osX lanes 0
- Rotate wrap: isb[2]=0x8000000000000000, others 0 -> elt = {0, 0x1, 0, 0x8000000000000000, 0}.
- Back-to-back: 4 consecutive random states with sample=1 -> 4 consecutive good cycles. Each cycle's elt and osX match a reference model of C/D, in order.
- Hold: inject state S, raise hold for 3 cycles starting the cycle after sample -> good appears 5 cycles after sample. Outputs are stable with the correct values, and a sample=1 asserted during hold is not captured.
- Reset mid-flight: sample at cycle 0, rst=0 at cycle 1 -> good never rises for that state. A new sample after release yields good 2 cycles later with correct data.
